// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, status bit positions and the shared TX/RX state
// encoding for the memory-mapped UART.
package uart_pkg;

  localparam logic DATA_OFS   = 1'b0;
  localparam logic STATUS_OFS = 1'b1;

  localparam int unsigned TXRDY = 0;
  localparam int unsigned RXAV  = 1;
  localparam int unsigned OVR   = 2;
  localparam int unsigned FRM   = 3;
  localparam int unsigned PAR   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartState_t;

  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small receive FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate count.
module uart_rx_fifo #(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic [7:0]  mem [RX_DEPTH];
  logic        doPush;
  logic        doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  // A push into a full FIFO still lands when the same edge frees a slot.
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr[AW-1:0]] <= din;
        wrPtr              <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART (DATA at 0xBF00, STATUS at 0xBF01) with a
// one-deep TX holding register and RX FIFO. Define UART_PARITY_EN for 8E1 frames.
module uart_mmio #(
  parameter int unsigned DIVISOR  = 434,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        addr0,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] dataWrite,
  output logic [15:0] dataRead,
  input  logic        uartRx,
  output logic        uartTx
);

  import uart_pkg::*;

  localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);
  localparam logic [15:0] DIV_HALF = 16'(DIVISOR / 2);

  logic dataWr;
  logic dataRd;
  logic statusRd;
  logic unusedDataHi;

  assign dataWr       = sel && we && (addr0 == DATA_OFS);
  assign dataRd       = sel && re && (addr0 == DATA_OFS);
  assign statusRd     = sel && re && (addr0 == STATUS_OFS);
  assign unusedDataHi = ^dataWrite[15:8];

  uartState_t  txState;
  logic [15:0] txCnt;
  logic [2:0]  txBit;
  logic [7:0]  txShift;
  logic [7:0]  holdData;
  logic        holdFull;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState  <= IDLE;
      txCnt    <= '0;
      txBit    <= '0;
      txShift  <= '0;
      holdData <= '0;
      holdFull <= 1'b0;
      uartTx   <= 1'b1;
    end else begin
      // Holding-register load and transfer are exclusive: one needs it empty, the other full.
      if (dataWr && !holdFull) begin
        holdFull <= 1'b1;
        holdData <= dataWrite[7:0];
      end
      case (txState)
        IDLE: begin
          if (holdFull) begin
            txShift  <= holdData;
            holdFull <= 1'b0;
            txCnt    <= '0;
            txState  <= START;
            uartTx   <= 1'b0;
          end else begin
            uartTx <= 1'b1;
          end
        end
        START: begin
          if (txCnt == DIV_LAST) begin
            txCnt   <= '0;
            txBit   <= '0;
            txState <= DATA;
            uartTx  <= txShift[0];
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        DATA: begin
          if (txCnt == DIV_LAST) begin
            txCnt <= '0;
            if (txBit == 3'd7) begin
`ifdef UART_PARITY_EN
              txState <= PARITY;
              uartTx  <= evenParity(txShift);
`else
              txState <= STOP;
              uartTx  <= 1'b1;
`endif
            end else begin
              txBit  <= txBit + 3'd1;
              uartTx <= txShift[txBit + 3'd1];
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (txCnt == DIV_LAST) begin
            txCnt   <= '0;
            txState <= STOP;
            uartTx  <= 1'b1;
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (txCnt == DIV_LAST) begin
            txCnt <= '0;
            if (holdFull) begin
              txShift  <= holdData;
              holdFull <= 1'b0;
              txState  <= START;
              uartTx   <= 1'b0;
            end else begin
              txState <= IDLE;
              uartTx  <= 1'b1;
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        default: begin
          txState <= IDLE;
          uartTx  <= 1'b1;
        end
      endcase
    end
  end

  logic        rxMeta;
  logic        rxSync;
  logic        rxPrev;
  uartState_t  rxState;
  logic [15:0] rxCnt;
  logic [2:0]  rxBit;
  logic [7:0]  rxShift;
  logic        rxPush;
  logic        frmSet;
  logic        parSet;
`ifdef UART_PARITY_EN
  logic        rxParity;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta  <= 1'b1;
      rxSync  <= 1'b1;
      rxPrev  <= 1'b1;
      rxState <= IDLE;
      rxCnt   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
      rxPush  <= 1'b0;
      frmSet  <= 1'b0;
      parSet  <= 1'b0;
`ifdef UART_PARITY_EN
      rxParity <= 1'b0;
`endif
    end else begin
      rxMeta <= uartRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      rxPush <= 1'b0;
      frmSet <= 1'b0;
      parSet <= 1'b0;
      case (rxState)
        IDLE: begin
          if (rxPrev && !rxSync) begin
            rxState <= START;
            rxCnt   <= DIV_HALF;
          end
        end
        START: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else if (!rxSync) begin
            rxState <= DATA;
            rxBit   <= '0;
            rxCnt   <= DIV_LAST;
          end else begin
            rxState <= IDLE;
          end
        end
        DATA: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else begin
            rxShift[rxBit] <= rxSync;
            rxCnt          <= DIV_LAST;
            if (rxBit == 3'd7) begin
`ifdef UART_PARITY_EN
              rxState <= PARITY;
`else
              rxState <= STOP;
`endif
            end else begin
              rxBit <= rxBit + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else begin
            rxParity <= rxSync;
            rxCnt    <= DIV_LAST;
            rxState  <= STOP;
          end
        end
`endif
        STOP: begin
          if (rxCnt != '0) begin
            rxCnt <= rxCnt - 16'd1;
          end else begin
            // Returning to IDLE at mid-stop lets the next start edge be caught.
            rxState <= IDLE;
            if (rxSync) begin
              rxPush <= 1'b1;
`ifdef UART_PARITY_EN
              parSet <= (rxParity != evenParity(rxShift));
`endif
            end else begin
              frmSet <= 1'b1;
            end
          end
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  logic       fifoFull;
  logic       fifoEmpty;
  logic [7:0] fifoHead;

  uart_rx_fifo #(.RX_DEPTH(RX_DEPTH)) rxFifo (
    .clk  (clk),
    .rst  (rst),
    .push (rxPush),
    .pop  (dataRd),
    .din  (rxShift),
    .dout (fifoHead),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

  logic overrun;
  logic frameErr;
  logic parErr;

  // Sticky flags: a STATUS read clears them, but a set on the same edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      frameErr <= 1'b0;
      parErr   <= 1'b0;
    end else begin
      overrun  <= (rxPush && fifoFull && !dataRd) || (overrun && !statusRd);
      frameErr <= frmSet || (frameErr && !statusRd);
      parErr   <= parSet || (parErr && !statusRd);
    end
  end

  always_comb begin
    dataRead = '0;
    if (sel) begin
      if (addr0 == DATA_OFS) begin
        if (!fifoEmpty) begin
          dataRead[7:0] = fifoHead;
        end
      end else begin
        dataRead[TXRDY] = !holdFull;
        dataRead[RXAV]  = !fifoEmpty;
        dataRead[OVR]   = overrun;
        dataRead[FRM]   = frameErr;
        dataRead[PAR]   = parErr;
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed and randomized bench for uart_mmio against a frame-level
// reference model. Honours UART_PARITY_EN for 8E1 frames.
`timescale 1ns/1ps
module tb_uart_mmio;

  localparam int unsigned DIV   = 8;
  localparam int unsigned DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        addr0 = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] dataWrite = '0;
  logic [15:0] dataRead;
  logic        uartRx = 1'b1;
  logic        uartTx;

  uart_mmio #(.DIVISOR(DIV), .RX_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .addr0    (addr0),
    .we       (we),
    .re       (re),
    .dataWrite(dataWrite),
    .dataRead (dataRead),
    .uartRx   (uartRx),
    .uartTx   (uartTx)
  );

  always #5 clk = ~clk;

  int  nChecks = 0;
  int  nFails  = 0;
  bit  checking = 1'b0;
  bit  rxBusy = 1'b0;

  // Reference model: TX as a frame timeline, RX as a byte queue plus flags.
  bit          mHold, mActive, mOvr, mFrm, mPar, oldHold;
  logic [7:0]  mHoldByte, mFrame;
  int unsigned mPos;
  logic [7:0]  rxQ[$];

  function automatic logic frameBit(input logic [7:0] b, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NBITS == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic expLine();
    return mActive ? frameBit(mFrame, mPos / DIV) : 1'b1;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mHold = 0; mActive = 0; mPos = 0; mOvr = 0; mFrm = 0; mPar = 0;
      rxQ.delete();
    end else begin
      oldHold = mHold;
      if (mActive) begin
        mPos++;
        if (mPos == FRAME) mActive = 0;
      end
      if (!mActive && oldHold) begin
        mActive = 1; mPos = 0; mFrame = mHoldByte; mHold = 0;
      end
      if (sel && we && !addr0 && !oldHold) begin
        mHold = 1; mHoldByte = dataWrite[7:0];
      end
      if (sel && re && !addr0 && rxQ.size() > 0) void'(rxQ.pop_front());
      if (sel && re && addr0) begin
        mOvr = 0; mFrm = 0; mPar = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("uartTx", {15'b0, uartTx}, {15'b0, expLine()});
      if (!sel) begin
        chk("idleBus", dataRead, 16'h0000);
      end else if (!addr0) begin
        if (!rxBusy) chk("dataRd", dataRead, {8'h00, (rxQ.size() > 0) ? rxQ[0] : 8'h00});
      end else begin
        logic [15:0] expStat, mask;
        expStat = {11'b0, mPar, mFrm, mOvr, rxQ.size() != 0, !mHold};
        mask    = rxBusy ? 16'h0001 : 16'hFFFF;
        chk("statusRd", dataRead & mask, expStat & mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic a, input logic [7:0] d);
    sel = 1; we = 1; addr0 = a; dataWrite = {8'($urandom), d};
    tick();
    sel = 0; we = 0;
  endtask

  task automatic busRead(input logic a, output logic [15:0] v);
    sel = 1; re = 1; addr0 = a;
    @(negedge clk);
    v = dataRead;
    tick();
    sel = 0; re = 0;
  endtask

  task automatic sendRx(input logic [7:0] b, input bit goodStop, input bit goodPar);
    rxBusy = 1;
    for (int unsigned i = 0; i < NBITS; i++) begin
      logic v;
      v = frameBit(b, i);
      if (NBITS == 11 && i == 9 && !goodPar) v = ~v;
      if (i == NBITS - 1 && !goodStop) v = 1'b0;
      uartRx = v;
      repeat (DIV) tick();
    end
    uartRx = 1'b1;
    repeat (2 * DIV) tick();
    if (!goodStop) begin
      mFrm = 1;
    end else begin
      if (NBITS == 11 && !goodPar) mPar = 1;
      if (rxQ.size() < DEPTH) rxQ.push_back(b);
      else mOvr = 1;
    end
    rxBusy = 0;
  endtask

  task automatic rxGlitch();
    rxBusy = 1;
    uartRx = 1'b0;
    repeat (2) tick();
    uartRx = 1'b1;
    repeat (3 * DIV) tick();
    rxBusy = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, v2;
`ifdef UART_PARITY_EN
    logic [10:0] t2Bits = 11'b10101001010;
`else
    logic [9:0]  t2Bits = 10'b1101001010;
`endif
    int unsigned r;

    repeat (3) tick();
    rst = 0;
    checking = 1;

    busRead(1, v); chk("t1Status", v, 16'h0001);
    chk("t1Tx", {15'b0, uartTx}, 16'h0001);
    busRead(0, v); chk("t1Data", v, 16'h0000);

    busWrite(0, 8'hA5);
    busRead(1, v); chk("t2TxBusy", v, 16'h0000);
    busRead(1, v); chk("t2TxReady", v, 16'h0001);
    repeat (3) tick();
    for (int unsigned k = 0; k < NBITS; k++) begin
      chk("t2Bit", {15'b0, uartTx}, {15'b0, t2Bits[k]});
      repeat (DIV) tick();
    end
    repeat (4) tick();

    busWrite(0, 8'h55);
    repeat (20) tick();
    busWrite(0, 8'h0F);
    repeat (2) tick();
    busWrite(0, 8'hAA);
    repeat (FRAME - 19) tick();
    chk("t3BackToBack", {15'b0, uartTx}, 16'h0000);
    repeat (FRAME) tick();
    chk("t3Dropped", {15'b0, uartTx}, 16'h0001);
    busRead(1, v); chk("t3Status", v, 16'h0001);
    repeat (2 * DIV) tick();

    sendRx(8'h3C, 1, 1);
    busRead(1, v); chk("t4Status", v, 16'h0003);
    busRead(0, v); chk("t4Data", v, 16'h003C);
    busRead(1, v); chk("t4Empty", v, 16'h0001);

    for (int unsigned i = 0; i < 5; i++) sendRx(8'((i + 1) * 17), 1, 1);
    busRead(1, v); chk("t5Overrun", v, 16'h0007);
    busRead(1, v); chk("t5Cleared", v, 16'h0003);
    for (int unsigned i = 0; i < 4; i++) begin
      busRead(0, v); chk("t5Data", v, {8'h00, 8'((i + 1) * 17)});
    end
    busRead(1, v); chk("t5Drained", v, 16'h0001);

    sendRx(8'hA7, 0, 1);
    busRead(1, v); chk("t6Frame", v, 16'h0009);
    busRead(1, v); chk("t6FrameClr", v, 16'h0001);
    busRead(0, v); chk("t6NoPush", v, 16'h0000);
    rxGlitch();
    busRead(1, v); chk("t6Glitch", v, 16'h0001);
    busRead(0, v); chk("t6GlitchData", v, 16'h0000);
`ifdef UART_PARITY_EN
    sendRx(8'h5A, 1, 0);
    busRead(1, v); chk("t6Parity", v, 16'h0013);
    busRead(0, v); chk("t6ParData", v, 16'h005A);
    busRead(1, v); chk("t6ParClr", v, 16'h0001);
`endif

    busWrite(0, 8'hC3);
    repeat (30) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rstTx", {15'b0, uartTx}, 16'h0001);
    busRead(1, v); chk("rstStatus", v, 16'h0001);

    fork
      begin
        for (int n = 0; n < 2500; n++) begin
          r = $urandom_range(0, 9);
          if (r < 3) busWrite(0, 8'($urandom));
          else if (r == 3) busWrite(1, 8'($urandom));
          else if (r < 6 && !rxBusy) busRead(1, v2);
          else if (r < 8 && !rxBusy) busRead(0, v2);
          else tick();
        end
      end
      begin
        for (int n = 0; n < 10; n++) begin
          repeat ($urandom_range(0, 40)) tick();
          if ($urandom_range(0, 7) == 0) rxGlitch();
          else sendRx(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
        end
      end
    join

    repeat (3 * FRAME) tick();
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
